// File: rtl/free_list.sv
// free_list: circular FIFO of free physical register numbers, popped by rename, pushed by ROB retirement
// Ports:
//   clk, reset (sync, active-low)
//   alloc_req / alloc_preg / alloc_ok : rename pops the head preg when alloc_ok
//   free_en / free_preg               : retirement pushes an old preg (p0 never recycled)
//   ckpt_en / ckpt_tag                : snapshot read pointer for a branch, indexed by ROB tag
//   mispredict / mispredict_tag       : restore read pointer from the branch's snapshot
//   count / empty / overflow_err      : occupancy, empty flag, sticky push-while-full flag
module free_list #(
  parameter int NUM_PREG  = 128,
  parameter int NUM_ARCH  = 32,
  parameter int DEPTH     = NUM_PREG - NUM_ARCH,
  parameter int PREG_W    = 7,
  parameter int TAG_W     = 5,
  parameter int ROB_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_req,
  output logic [PREG_W-1:0] alloc_preg,
  output logic              alloc_ok,
  input  logic              free_en,
  input  logic [PREG_W-1:0] free_preg,
  input  logic              ckpt_en,
  input  logic [TAG_W-1:0]  ckpt_tag,
  input  logic              mispredict,
  input  logic [TAG_W-1:0]  mispredict_tag,
  output logic [6:0]        count,
  output logic              empty,
  output logic              overflow_err
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(ROB_DEPTH);
  logic [PREG_W-1:0] mem [DEPTH];
  logic [IW:0] ckpt [ROB_DEPTH];
  logic [IW:0] rptr, wptr, rptr_pop;
  logic full, pop, push_try, push;
  logic unused_tag;
  // pointer is {wrap, index}; index wraps at DEPTH-1 rather than a power of two
  function automatic logic [IW:0] inc(input logic [IW:0] p);
    return (p[IW-1:0] == IW'(DEPTH - 1)) ? {~p[IW], IW'(0)} : p + 1'b1;
  endfunction
  assign unused_tag = ^{ckpt_tag[TAG_W-1:CW], mispredict_tag[TAG_W-1:CW]};
  assign count = (rptr[IW] == wptr[IW]) ? 7'(wptr[IW-1:0]) - 7'(rptr[IW-1:0])
                                        : 7'(DEPTH) + 7'(wptr[IW-1:0]) - 7'(rptr[IW-1:0]);
  assign empty      = count == 7'd0;
  assign full       = count == 7'(DEPTH);
  assign alloc_ok   = !empty;
  assign alloc_preg = mem[rptr[IW-1:0]];
  assign pop        = alloc_req && !empty && !mispredict;
  assign push_try   = free_en && free_preg != '0;
  // a same-cycle pop frees a slot, so a push into a full list is still accepted
  assign push       = push_try && (!full || pop);
  assign rptr_pop   = pop ? inc(rptr) : rptr;
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= PREG_W'(NUM_ARCH + i);
      for (int i = 0; i < ROB_DEPTH; i++) ckpt[i] <= '0;
      rptr         <= '0;
      wptr         <= {1'b1, IW'(0)};
      overflow_err <= 1'b0;
    end else begin
      rptr <= mispredict ? ckpt[mispredict_tag[CW-1:0]] : rptr_pop;
      if (push) begin
        mem[wptr[IW-1:0]] <= free_preg;
        wptr              <= inc(wptr);
      end
      if (push_try && !push) overflow_err <= 1'b1;
      // snapshot includes the branch's own same-cycle allocation
      if (ckpt_en && !mispredict) ckpt[ckpt_tag[CW-1:0]] <= rptr_pop;
    end
  end
endmodule
